// File: rtl/console_rx_fifo.sv
// rtl/console_rx_fifo.sv - receive FIFO draining the simpleuart byte register into a non-blocking CPU pop port
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   uart_dat_do  UART receive register; byte in [7:0], all-ones when no byte is held
//   uart_dat_re  one-cycle consume pulse back to the UART
//   rd_re        CPU pop strobe
//   rd_data      head byte zero-extended, 0 when empty
//   rd_valid     FIFO not empty
//   flush        synchronous clear of contents and overrun
//   level        bytes held, 0..DEPTH
//   full         level == DEPTH
//   overrun      sticky: a byte waited at the UART while the FIFO was full
module console_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           uart_dat_do,
    output logic                  uart_dat_re,
    input  logic                  rd_re,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = LEVEL_ONE[DEPTH_LOG2-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overrun;
    logic                  r_uart_dat_re;
    state_t                r_state;

    state_t                w_next_state;
    logic                  w_uart_valid;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_capture;
    logic                  w_overflow;
    logic                  w_pop;

    assign w_uart_valid = (uart_dat_do != 32'hFFFF_FFFF);
    assign w_full       = (r_level == LEVEL_FULL);
    assign w_empty      = (r_level == '0);
    assign w_pop        = rd_re && !w_empty;

    // Drain FSM. After each ack the UART gets two cycles (ACK, SETTLE)
    // to retire its valid before IDLE samples again, so one byte is never
    // captured twice. full is the pre-edge value, so a same-cycle pop at
    // DEPTH does not open room until the next IDLE sample.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_overflow   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_uart_valid) begin
                    if (!w_full) begin
                        w_capture    = 1'b1;
                        w_next_state = S_ACK;
                    end else begin
                        w_overflow   = 1'b1;
                    end
                end
            end
            S_ACK:    w_next_state = S_SETTLE;
            S_SETTLE: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Flush deliberately leaves the handshake alone so an in-flight ack
    // still completes toward the UART.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_uart_dat_re <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_uart_dat_re <= w_capture;
        end
    end

    // Storage is not reset; level gates every read of it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wptr] <= uart_dat_do[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else if (flush) begin
            // A capture in this same cycle is dropped here.
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_capture, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_overflow) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign uart_dat_re = r_uart_dat_re;
    assign rd_valid    = !w_empty;
    assign rd_data     = w_empty ? 32'h0000_0000 : {24'h00_0000, r_mem[r_rptr]};
    assign level       = r_level;
    assign full        = w_full;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_console_rx_fifo.sv
// tb/tb_console_rx_fifo.sv - self-checking bench for console_rx_fifo against a queue-based reference model
`timescale 1ns/1ps
module tb_console_rx_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] uart_dat_do;
    logic        uart_dat_re;
    logic        rd_re;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        flush;
    logic [4:0]  level;
    logic        full;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // One-byte UART holding register.
    bit         u_has = 1'b0;
    logic [7:0] u_byte = 8'h00;
    assign uart_dat_do = u_has ? {24'h0, u_byte} : 32'hFFFF_FFFF;

    // Reference model: a byte queue, a cooldown of two clocks after every
    // accepted byte before the UART is looked at again, and a sticky flag.
    byte unsigned mq[$];
    int           m_cool = 0;
    bit           m_ovr = 1'b0;

    always #5 clk = ~clk;

    console_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_dat_do (uart_dat_do),
        .uart_dat_re (uart_dat_re),
        .rd_re       (rd_re),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .flush       (flush),
        .level       (level),
        .full        (full),
        .overrun     (overrun)
    );

    function automatic logic [31:0] exp_data();
        if (mq.size() == 0) return 32'h0;
        return {24'h0, mq[0]};
    endfunction

    // Advance model and DUT by one clock; inputs are pulses cleared afterwards.
    task automatic tick();
        bit cap;
        bit ovf;
        bit pop;
        cap = 1'b0;
        ovf = 1'b0;
        pop = rd_re && (mq.size() != 0);
        if (!resetn) begin
            mq.delete();
            m_cool = 0;
            m_ovr  = 1'b0;
        end else begin
            if (m_cool > 0) m_cool--;
            else if (u_has) begin
                if (mq.size() < 16) cap = 1'b1;
                else ovf = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (cap) begin
                mq.push_back(u_byte);
                m_cool = 2;
            end
            if (ovf) m_ovr = 1'b1;
            if (flush) begin
                mq.delete();
                m_ovr = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (cap) u_has = 1'b0;
        rd_re = 1'b0;
        flush = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g;
        u_byte = b;
        u_has  = 1'b1;
        g      = 0;
        while (u_has && g < 20) begin
            tick();
            g++;
        end
        if (u_has) begin
            checks++;
            errors++;
            $display("FAIL push_timeout byte %02h still pending after %0d cycles, required captured", b, g);
            u_has = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rd_re  = 1'b0;
        flush  = 1'b0;
        u_byte = 8'h41;
        u_has  = 1'b1;
        tick();
        tick();
        checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL reset_re got %0b exp 0", uart_dat_re); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %08h exp 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
        resetn = 1'b1;
        tick();
        checks++; if (uart_dat_re !== 1'b1) begin errors++; $display("FAIL first_ack got %0b exp 1", uart_dat_re); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL first_level got %0d exp 1", level); end
        checks++; if (rd_data !== 32'h0000_0041) begin errors++; $display("FAIL first_data got %08h exp 00000041", rd_data); end
        tick();
        checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %0b exp 0", uart_dat_re); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL no_double_capture got %0d exp 1", level); end
    endtask

    task automatic test_order();
        logic [7:0] b [3];
        b[0] = 8'h48; b[1] = 8'h69; b[2] = 8'h21;
        flush = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push_byte(b[i]);
        tick(); tick(); tick();
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL order_level got %0d exp 3", level); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_data !== {24'h0, b[i]}) begin errors++; $display("FAIL order_pop%0d got %08h exp %02h", i, rd_data, b[i]); end
            rd_re = 1'b1;
            tick();
        end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL order_empty_data got %08h exp 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL order_empty_valid got %0b exp 0", rd_valid); end
    endtask

    task automatic test_full_overrun();
        flush = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        tick(); tick();
        checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_level got %0d/%0b exp 16/1", level, full); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_no_ovr got %0b exp 0", overrun); end
        u_byte = 8'h10;
        u_has  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL full_no_ack cyc%0d got %0b exp 0", i, uart_dat_re); end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b exp 1", overrun); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_hold_level got %0d exp 16", level); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL full_head got %08h exp 00000000", rd_data); end
        rd_re = 1'b1;
        tick();
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_pop_level got %0d exp 15", level); end
        tick();
        checks++; if (uart_dat_re !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL refill got re=%0b lvl=%0d exp re=1 lvl=16", uart_dat_re, level); end
        tick(); tick(); tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b exp 1", overrun); end
        checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL refill_head got %08h exp 00000001", rd_data); end
        flush = 1'b1;
        tick();
        checks++; if (overrun !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL flush_clear got ovr=%0b lvl=%0d exp 0/0", overrun, level); end
    endtask

    task automatic test_simultaneous();
        flush = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        tick(); tick();
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_pre got %0d exp 5", level); end
        u_byte = 8'hB5;
        u_has  = 1'b1;
        rd_re  = 1'b1;
        tick();
        checks++; if (uart_dat_re !== 1'b1) begin errors++; $display("FAIL simul_ack got %0b exp 1", uart_dat_re); end
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_level got %0d exp 5", level); end
        checks++; if (rd_data !== 32'hA1) begin errors++; $display("FAIL simul_head got %08h exp 000000a1", rd_data); end
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i));
            checks++; if (rd_data !== 32'(i) || level !== 5'd1) begin errors++; $display("FAIL wrap%0d got %08h lvl=%0d exp %08h lvl=1", i, rd_data, level, i); end
            rd_re = 1'b1;
            tick();
        end
        checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got lvl=%0d exp 0", level); end
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        tick();
        tick(); tick(); tick();
        rd_re = 1'b1;
        tick();
        checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL empty_pop got lvl=%0d v=%0b d=%08h exp 0/0/0", level, rd_valid, rd_data); end
        for (int i = 0; i < 6; i++) push_byte(8'h70 + 8'(i));
        tick(); tick();
        push_byte(8'h77);
        checks++; if (level !== 5'd7 || uart_dat_re !== 1'b1) begin errors++; $display("FAIL pre_flush got lvl=%0d re=%0b exp 7/1", level, uart_dat_re); end
        flush = 1'b1;
        tick();
        checks++; if (level !== 5'd0 || overrun !== 1'b0) begin errors++; $display("FAIL flush_ack got lvl=%0d ovr=%0b exp 0/0", level, overrun); end
        checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL flush_re_fall got %0b exp 0", uart_dat_re); end
        tick();
        push_byte(8'h5A);
        checks++; if (level !== 5'd1 || rd_data !== 32'h5A) begin errors++; $display("FAIL post_flush got lvl=%0d d=%08h exp 1/0000005a", level, rd_data); end
    endtask

    task automatic test_random();
        int pop_div;
        flush = 1'b1;
        tick();
        for (int c = 0; c < 600; c++) begin
            pop_div = (c < 300) ? 8 : 2;
            if (!u_has && ($urandom % 2 == 0)) begin
                u_byte = 8'($urandom);
                u_has  = 1'b1;
            end
            rd_re = ($urandom % pop_div == 0);
            flush = ($urandom % 60 == 0);
            tick();
            checks++; if (level !== 5'(mq.size())) begin errors++; $display("FAIL rnd_level c=%0d got %0d exp %0d", c, level, mq.size()); end
            checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL rnd_data c=%0d got %08h exp %08h", c, rd_data, exp_data()); end
            checks++; if (rd_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, rd_valid, mq.size() != 0); end
            checks++; if (full !== (mq.size() == 16)) begin errors++; $display("FAIL rnd_full c=%0d got %0b exp %0b", c, full, mq.size() == 16); end
            checks++; if (uart_dat_re !== (m_cool == 2)) begin errors++; $display("FAIL rnd_re c=%0d got %0b exp %0b", c, uart_dat_re, m_cool == 2); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr c=%0d got %0b exp %0b", c, overrun, m_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overrun();
        test_simultaneous();
        test_wrap();
        test_flush_empty();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
